// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage.
// Logic/shift/arith datapath plus a 32-step restoring divider.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  alusel_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic        annul_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stall_req_o
);

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_ARITH = 3'b100;

   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ZERO,
      S_ON,
      S_END
   } div_state_e;

   div_state_e  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        neg_q, neg_d;
   logic        rsgn_q, rsgn_d;

   logic        is_div;
   logic        is_sdiv;
   logic [4:0]  sh;
   logic [31:0] logic_res;
   logic [31:0] shift_res;
   logic [31:0] arith_res;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] trial;
   logic [33:0] diff;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic        stall;
   logic        whilo;

   assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
   assign is_sdiv = (aluop_i == OP_DIV);
   assign sh      = reg1_i[4:0];

   assign wd_o   = wd_i;
   assign wreg_o = wreg_i & ~is_div;

   // Bitwise logic group
   always_comb begin
      logic_res = '0;
      case (aluop_i)
         OP_AND:  logic_res = reg1_i & reg2_i;
         OP_OR:   logic_res = reg1_i | reg2_i;
         OP_XOR:  logic_res = reg1_i ^ reg2_i;
         OP_NOR:  logic_res = ~(reg1_i | reg2_i);
         default: logic_res = '0;
      endcase
   end

   // Shift group: amount from reg1, value from reg2
   always_comb begin
      shift_res = '0;
      case (aluop_i)
         OP_SLL:  shift_res = reg2_i << sh;
         OP_SRL:  shift_res = reg2_i >> sh;
         OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> sh);
         default: shift_res = '0;
      endcase
   end

   // Add/sub/compare group; divide ops leave wdata at zero
   always_comb begin
      arith_res = '0;
      case (aluop_i)
         OP_ADDU: arith_res = reg1_i + reg2_i;
         OP_SUBU: arith_res = reg1_i - reg2_i;
         OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
         OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
         default: arith_res = '0;
      endcase
   end

   // Result group select
   always_comb begin
      wdata_o = '0;
      case (alusel_i)
         SEL_LOGIC: wdata_o = logic_res;
         SEL_SHIFT: wdata_o = shift_res;
         SEL_ARITH: wdata_o = arith_res;
         default:   wdata_o = '0;
      endcase
   end

   // Operand magnitudes and one restoring shift-subtract step
   always_comb begin
      a_mag = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
      b_mag = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
      trial = {rem_q, quo_q[31]};
      diff  = {1'b0, trial} - {2'b00, dvs_q};
      if (!diff[33]) begin
         rem_step = diff[31:0];
         quo_step = {quo_q[30:0], 1'b1};
      end else begin
         rem_step = trial[31:0];
         quo_step = {quo_q[30:0], 1'b0};
      end
   end

   // Divider next-state, stall and HI/LO strobe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      neg_d   = neg_q;
      rsgn_d  = rsgn_q;
      stall   = 1'b0;
      whilo   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (is_div && !annul_i) begin
               stall = 1'b1;
               if (reg2_i == 32'd0) begin
                  state_d = S_ZERO;
               end else begin
                  dvs_d   = b_mag;
                  quo_d   = a_mag;
                  rem_d   = '0;
                  cnt_d   = '0;
                  neg_d   = is_sdiv & (reg1_i[31] ^ reg2_i[31]);
                  rsgn_d  = is_sdiv & reg1_i[31];
                  state_d = S_ON;
               end
            end
         end
         S_ZERO: begin
            stall   = 1'b1;
            rem_d   = '0;
            quo_d   = '0;
            state_d = S_END;
         end
         S_ON: begin
            stall = 1'b1;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               rem_d   = rsgn_q ? (~rem_step + 32'd1) : rem_step;
               quo_d   = neg_q ? (~quo_step + 32'd1) : quo_step;
               state_d = S_END;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
            end
         end
         S_END: begin
            whilo   = 1'b1;
            state_d = S_IDLE;
         end
      endcase
      if (annul_i) begin
         stall   = 1'b0;
         whilo   = 1'b0;
         state_d = S_IDLE;
      end
   end

   assign stall_req_o = stall & ~rst;
   assign whilo_o     = whilo;
   assign hi_o        = whilo ? rem_q : 32'd0;
   assign lo_o        = whilo ? quo_q : 32'd0;

   // Divider state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         neg_q   <= 1'b0;
         rsgn_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         neg_q   <= neg_d;
         rsgn_q  <= rsgn_d;
      end
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS32 pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its registered outputs: operation type, sub-type, two operands, destination address and write enable. It computes logic, shift and add/compare results combinationally. It also contains an iterative 32-cycle radix-2 divider for DIV/DIVU, which writes HI/LO and holds the pipeline through a stall request. Results feed the EX/MEM pipeline register.

## Interface
- No parameters; widths fixed: data 32, register address 5, alusel 3, aluop 8.
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alusel_i  in  3  operation type: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITHMETIC.
- aluop_i  in  8  sub-type:
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27
  - SLL 0x7C, SRL 0x02, SRA 0x03
  - ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B
  - DIV 0x1A, DIVU 0x1B, NOP 0x00
- reg1_i  in  32  operand 1 (dividend for DIV/DIVU).
- reg2_i  in  32  operand 2 (divisor; shift value for shifts).
- wd_i  in  5  destination GPR address.
- wreg_i  in  1  GPR write enable from decode.
- annul_i  in  1  flush: abort any division in progress.
- wd_o  out  5  equals wd_i.
- wreg_o  out  1  equals wreg_i, except 0 for DIV/DIVU.
- wdata_o  out  32  GPR write data.
- whilo_o  out  1  HI/LO write strobe; high only in the division END cycle.
- hi_o  out  32  remainder; 0 when whilo_o=0.
- lo_o  out  32  quotient; 0 when whilo_o=0.
- stall_req_o  out  1  request to freeze PC, IF/ID and ID/EX.

## Operation
- Combinational datapath; result group selected by alusel_i.
  - Unknown alusel or aluop gives wdata_o=0.
  - DIV/DIVU give wdata_o=0.
- Shifts: amount is reg1_i[4:0]; value shifted is reg2_i; SRA sign-fills.
- ADDU/SUBU: modulo 2^32, no overflow trap.
- SLT: signed compare gives 1/0. SLTU: unsigned compare gives 1/0.
- Divider FSM states: IDLE, ZERO, ON, END.
  - IDLE: when aluop_i is DIV/DIVU and annul_i=0, assert stall_req_o.
    - Divisor 0: go to ZERO.
    - Otherwise: latch magnitudes (DIV negates negative operands), clear counter, go to ON.
  - ZERO: stall_req_o=1; go to END with quotient=0, remainder=0.
  - ON: one restoring shift-subtract step per cycle; stall_req_o=1.
    - 6-bit counter increments each cycle.
    - After the 32nd step, apply DIV sign fix and go to END.
    - Sign fix: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - END: stall_req_o=0, whilo_o=1, hi_o/lo_o show the result. Unconditionally return to IDLE at the next edge.
- In END the pipeline advances at the closing edge, so the same division is never restarted.
- annul_i=1 in any state: stall_req_o=0 and whilo_o=0 in that cycle; FSM goes to IDLE at the next edge.

## Timing
- Non-divide ops: zero-cycle (combinational) latency, no stall.
- DIV/DIVU issue cycle N (IDLE):
  - stall_req_o high in cycles N..N+32 (33 cycles), covering ON in N+1..N+32.
  - END in cycle N+33: whilo_o=1, stall_req_o=0.
- Divide by zero: stall_req_o high in N and N+1 (ZERO); END in N+2.
- Upstream holds all inputs stable while stall_req_o=1. The block does not re-sample operands after the issue cycle.
- Reset (async, any time, including mid-division):
  - FSM to IDLE; counter and divider registers cleared.
  - stall_req_o=0, whilo_o=0, hi_o=lo_o=0.
  - Combinational outputs follow inputs (reset ID/EX yields NOP: wdata_o=0, wreg_o=0, wd_o=0).
- Simultaneous annul_i and new DIV in IDLE: annul wins; no division starts.

## Test plan
- Logic/shift/arith:
  - OR 0x0F0F0000, 0x0000F0F0 -> wdata_o=0x0F0FF0F0, no stall.
  - SRA reg1=4, reg2=0x80000000 -> 0xF8000000.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
- DIV 7 / -2 (0xFFFFFFFE):
  - stall_req_o high exactly 33 cycles.
  - END cycle: whilo_o=1, lo_o=0xFFFFFFFD, hi_o=1, wreg_o=0.
- DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF.
- DIVU x / 0:
  - stall_req_o high 2 cycles.
  - Next cycle whilo_o=1, hi_o=lo_o=0.
- Abort cases:
  - annul_i pulse 10 cycles into ON -> stall_req_o low that cycle, FSM IDLE next edge, whilo_o never asserted.
  - Async rst mid-ON -> outputs cleared immediately.
  - New DIV after reset completes normally.
